// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM controller for the multicycle MIPS datapath
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [3:0] ALUop,
  output logic       Illegal,
  output logic [3:0] State
);

  // ALU operation codes shared with the ALU
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_ADDU = 4'd11;
  localparam logic [3:0] ALU_SUBU = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_IF  = 4'd1, S_ID  = 4'd2,  S_EXE = 4'd3,
    S_MADR = 4'd4, S_MRD = 4'd5, S_MWR = 4'd6,  S_WBM = 4'd7,
    S_WBA  = 4'd8, S_BR  = 4'd9, S_JMP = 4'd10, S_JR  = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic       r_legal, i_legal, i_ext;
  logic [3:0] r_alu, i_alu;
  logic [1:0] r_srca;

  // State register; reset only aborts the sequence, nothing else is held here
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // R-type function decode: ALU op and A-operand source (shamt for immediate shifts)
  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_NOP;
    r_srca  = 2'b01;
    case (Funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100001: r_alu = ALU_ADDU;
      6'b100010: r_alu = ALU_SUB;
      6'b100011: r_alu = ALU_SUBU;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b101011: r_alu = ALU_SLTU;
      6'b000000: begin r_alu = ALU_SLL; r_srca = 2'b10; end
      6'b000010: begin r_alu = ALU_SRL; r_srca = 2'b10; end
      6'b000100: r_alu = ALU_SLL;
      6'b000110: r_alu = ALU_SRL;
      default:   r_legal = 1'b0;
    endcase
  end

  // I-type arithmetic decode: ALU op and immediate extension mode
  always_comb begin
    i_legal = 1'b1;
    i_alu   = ALU_NOP;
    i_ext   = 1'b0;
    case (Op)
      OP_ADDI: begin i_alu = ALU_ADD; i_ext = 1'b1; end
      OP_SLTI: begin i_alu = ALU_SLT; i_ext = 1'b1; end
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_LUI:  i_alu = ALU_LUI;
      default: i_legal = 1'b0;
    endcase
  end

  // Next state and Moore outputs; everything defaults to inactive / ALU_NOP
  always_comb begin
    state_d  = S_IF;
    PCWrite  = 1'b0;
    PCSource = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b0;
    ALUop    = ALU_NOP;
    Illegal  = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUop   = ALU_ADD;
        PCWrite = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        // ALUOut latches PC+4 + (sext imm << 2) as the branch target
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        ALUop   = ALU_ADD;
        case (Op)
          OP_RTYPE: begin
            if (Funct == F_JR) state_d = S_JR;
            else if (r_legal)  state_d = S_EXE;
            else               Illegal = 1'b1;
          end
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXE;
          OP_LW, OP_SW:   state_d = S_MADR;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J, OP_JAL:   state_d = S_JMP;
          default:        Illegal = 1'b1;
        endcase
      end
      S_EXE: begin
        state_d = S_WBA;
        if (Op == OP_RTYPE) begin
          ALUSrcA = r_srca;
          ALUop   = r_alu;
        end else begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ALUop   = i_alu;
          ExtOp   = i_ext;
        end
      end
      S_WBA: begin
        RegWrite = 1'b1;
        RegDst   = (Op == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      S_MADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        ALUop   = ALU_ADD;
        if (Op == OP_LW)      state_d = S_MRD;
        else if (Op == OP_SW) state_d = S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_WBM;
      end
      S_WBM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BR: begin
        ALUSrcA  = 2'b01;
        ALUop    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = (Op == OP_BNE) ? ~Zero : Zero;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        if (Op == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      default: state_d = S_IF;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3;
  localparam logic [3:0] A_OR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_NOR = 4'd7;
  localparam logic [3:0] A_SLL = 4'd8, A_SRL = 4'd9, A_LUI = 4'd10, A_ADDU = 4'd11;
  localparam logic [3:0] A_SUBU = 4'd12;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
  localparam int K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ext;
    logic [3:0] alu;
    logic       ill;
  } rec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, Illegal;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0] ALUop, State;

  int   n_checks = 0;
  int   n_errors = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];

  multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
    .ALUop(ALUop), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  function automatic rec_t sample();
    rec_t r;
    r.st = State; r.pcw = PCWrite; r.pcs = PCSource; r.iord = IorD;
    r.mr = MemRead; r.mw = MemWrite; r.irw = IRWrite; r.rw = RegWrite;
    r.rd = RegDst; r.m2r = MemtoReg; r.sa = ALUSrcA; r.sb = ALUSrcB;
    r.ext = ExtOp; r.alu = ALUop; r.ill = Illegal;
    return r;
  endfunction

  function automatic rec_t blank(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  // Reference: the per-cycle output trace of one whole instruction, IF first
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int         kind;
    logic [3:0] alu;
    logic [1:0] sa;
    logic       ext;
    rec_t       e;
    kind = K_ILL; alu = A_NOP; sa = 2'b01; ext = 1'b0;
    case (op)
      6'd0: begin
        kind = K_R;
        case (fn)
          6'h20: alu = A_ADD;  6'h21: alu = A_ADDU; 6'h22: alu = A_SUB;
          6'h23: alu = A_SUBU; 6'h24: alu = A_AND;  6'h25: alu = A_OR;
          6'h27: alu = A_NOR;  6'h2a: alu = A_SLT;  6'h2b: alu = A_SLTU;
          6'h00: begin alu = A_SLL; sa = 2'b10; end
          6'h02: begin alu = A_SRL; sa = 2'b10; end
          6'h04: alu = A_SLL;  6'h06: alu = A_SRL;
          6'h08: kind = K_JR;
          default: kind = K_ILL;
        endcase
      end
      6'd8:  begin kind = K_I; alu = A_ADD; ext = 1'b1; end
      6'd10: begin kind = K_I; alu = A_SLT; ext = 1'b1; end
      6'd12: begin kind = K_I; alu = A_AND; end
      6'd13: begin kind = K_I; alu = A_OR;  end
      6'd15: begin kind = K_I; alu = A_LUI; end
      6'd35: kind = K_LW;
      6'd43: kind = K_SW;
      6'd4:  kind = K_BEQ;
      6'd5:  kind = K_BNE;
      6'd2:  kind = K_J;
      6'd3:  kind = K_JAL;
      default: kind = K_ILL;
    endcase
    exp_q.delete();
    e = blank(4'd1); e.mr = 1; e.irw = 1; e.sb = 2'b01; e.alu = A_ADD; e.pcw = 1;
    exp_q.push_back(e);
    e = blank(4'd2); e.sb = 2'b11; e.ext = 1; e.alu = A_ADD; e.ill = (kind == K_ILL);
    exp_q.push_back(e);
    case (kind)
      K_R: begin
        e = blank(4'd3); e.sa = sa; e.sb = 2'b00; e.alu = alu; exp_q.push_back(e);
        e = blank(4'd8); e.rw = 1; e.rd = 2'b01; exp_q.push_back(e);
      end
      K_I: begin
        e = blank(4'd3); e.sa = 2'b01; e.sb = 2'b10; e.alu = alu; e.ext = ext;
        exp_q.push_back(e);
        e = blank(4'd8); e.rw = 1; exp_q.push_back(e);
      end
      K_LW, K_SW: begin
        e = blank(4'd4); e.sa = 2'b01; e.sb = 2'b10; e.ext = 1; e.alu = A_ADD;
        exp_q.push_back(e);
        if (kind == K_LW) begin
          e = blank(4'd5); e.mr = 1; e.iord = 1; exp_q.push_back(e);
          e = blank(4'd7); e.rw = 1; e.m2r = 2'b01; exp_q.push_back(e);
        end else begin
          e = blank(4'd6); e.mw = 1; e.iord = 1; exp_q.push_back(e);
        end
      end
      K_BEQ, K_BNE: begin
        e = blank(4'd9); e.sa = 2'b01; e.alu = A_SUB; e.pcs = 2'b01;
        e.pcw = (kind == K_BEQ) ? z : !z;
        exp_q.push_back(e);
      end
      K_J, K_JAL: begin
        e = blank(4'd10); e.pcw = 1; e.pcs = 2'b10;
        if (kind == K_JAL) begin e.rw = 1; e.rd = 2'b10; e.m2r = 2'b10; end
        exp_q.push_back(e);
      end
      K_JR: begin
        e = blank(4'd11); e.pcw = 1; e.pcs = 2'b11; exp_q.push_back(e);
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction from IF until the DUT is back in IF (bounded to 8 cycles)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_q.delete();
    Op = op; Funct = fn; Zero = z;
    #1;
    for (int i = 0; i < 8; i++) begin
      obs_q.push_back(sample());
      @(posedge clk); @(negedge clk); #1;
      if (State == 4'd1) break;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sample() !== rec_t'(0)) begin
      n_errors++; $display("FAIL reset_outputs got=%h exp=%h", sample(), rec_t'(0));
    end
    @(negedge clk); rstn = 1'b1; #1;
    n_checks++;
    if (State !== 4'd0) begin n_errors++; $display("FAIL reset_release_init got=%0d exp=0", State); end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (State !== 4'd1) begin n_errors++; $display("FAIL reset_first_if got=%0d exp=1", State); end
  endtask

  task automatic test_add();
    run_instr(6'd0, 6'h20, 1'b0);
    build(6'd0, 6'h20, 1'b0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL add_latency got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL add_cycle%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [5:0] ops [2];
    ops[0] = 6'd35; ops[1] = 6'd43;
    for (int k = 0; k < 2; k++) begin
      run_instr(ops[k], 6'($urandom), 1'($urandom));
      build(ops[k], 6'd0, 1'b0);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_errors++; $display("FAIL mem_latency op=%0d got=%0d exp=%0d", ops[k], obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL mem op=%0d cycle%0d got=%h exp=%h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      logic [5:0] op;
      logic       z;
      op = (k < 2) ? 6'd4 : 6'd5;
      z  = 1'(k);
      run_instr(op, 6'd0, z);
      build(op, 6'd0, z);
      n_checks++;
      if (obs_q.size() != 3) begin
        n_errors++; $display("FAIL branch_latency op=%0d got=%0d exp=3", op, obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL branch op=%0d zero=%0d cycle%0d got=%h exp=%h", op, z, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'd2; fns[0] = 6'd0;
    ops[1] = 6'd3; fns[1] = 6'd0;
    ops[2] = 6'd0; fns[2] = 6'h08;
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], fns[k], 1'($urandom));
      build(ops[k], fns[k], 1'b0);
      n_checks++;
      if (obs_q.size() != 3) begin
        n_errors++; $display("FAIL jump_latency op=%0d got=%0d exp=3", ops[k], obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL jump op=%0d cycle%0d got=%h exp=%h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'h3f; fns[0] = 6'h00;
    ops[1] = 6'h00; fns[1] = 6'h3f;
    ops[2] = 6'h01; fns[2] = 6'h20;
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], fns[k], 1'b1);
      build(ops[k], fns[k], 1'b1);
      n_checks++;
      if (obs_q.size() != 2) begin
        n_errors++; $display("FAIL illegal_latency op=%0d fn=%0d got=%0d exp=2", ops[k], fns[k], obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL illegal op=%0d fn=%0d cycle%0d got=%h exp=%h", ops[k], fns[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_shift_lui();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'd0;  fns[0] = 6'h00;
    ops[1] = 6'd0;  fns[1] = 6'h06;
    ops[2] = 6'd15; fns[2] = 6'h00;
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], fns[k], 1'b0);
      build(ops[k], fns[k], 1'b0);
      n_checks++;
      if (obs_q.size() != 4) begin
        n_errors++; $display("FAIL shift_lui_latency op=%0d got=%0d exp=4", ops[k], obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL shift_lui op=%0d fn=%0d cycle%0d got=%h exp=%h", ops[k], fns[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op_pool [15];
    logic [5:0] fn_pool [15];
    op_pool = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43,
                6'd4, 6'd5, 6'd2, 6'd3, 6'd0};
    fn_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
                6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h00};
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op, fn;
      logic       z;
      op = op_pool[$urandom_range(0, 14)];
      fn = fn_pool[$urandom_range(0, 14)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      z = 1'($urandom);
      run_instr(op, fn, z);
      build(op, fn, z);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_errors++; $display("FAIL random_latency op=%0d fn=%0d got=%0d exp=%0d", op, fn, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL random op=%0d fn=%0d cycle%0d got=%h exp=%h", op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [4];
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd10; seq[3] = 4'd1;
    Op = 6'd43; Funct = 6'd0; Zero = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #1;
    n_checks++;
    if (State !== 4'd6 || MemWrite !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_reach_mwr state=%0d memwrite=%0b exp 6/1", State, MemWrite);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (sample() !== rec_t'(0)) begin
      n_errors++; $display("FAIL reset_mid_async got=%h exp=%h", sample(), rec_t'(0));
    end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (sample() !== rec_t'(0)) begin
      n_errors++; $display("FAIL reset_mid_hold got=%h exp=%h", sample(), rec_t'(0));
    end
    Op = 6'd2;
    rstn = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0) begin n_errors++; $display("FAIL reset_mid_release got=%0d exp=0", State); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk); #1;
      n_checks++;
      if (State !== seq[i]) begin
        n_errors++; $display("FAIL reset_mid_seq step%0d got=%0d exp=%0d", i, State, seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_shift_lui();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
